// File: rtl/matrix_mult_4x4.sv
// matrix_mult_4x4: sequential unsigned integer matrix multiplier, up to 4x4.
// Computes one result element per clock into a shadow buffer. The full
// R1xC2 result is published on res_mat in a single update.
// Optional feature macro: MATMUL_DIMCHK_EN. When it is defined, bad
// dimensions are rejected at start and produce a zero result.
module matrix_mult_4x4 #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N*N*W-1:0] matrix_1,
  input  logic [N*N*W-1:0] matrix_2,
  input  logic [3:0]       R1,
  input  logic [3:0]       C1,
  input  logic [3:0]       R2,
  input  logic [3:0]       C2,
  input  logic             readybit,
  output logic [N*N*W-1:0] res_mat
);

  typedef enum logic {IDLE, COMPUTE} state_t;

  // Element k of each bus sits at bits [255-16k -: 16]. Ascending outer
  // indexing makes element 0 the most significant slice.
  typedef logic [0:N*N-1][W-1:0] mat_t;

  state_t r_state, w_next_state;

  logic       r_ready_q;
  logic       r_armed;
  logic       r_zero_pend;
  mat_t       r_a, r_b, r_shadow, r_res;
  logic [3:0] r_r1, r_c1, r_c2;
  logic [3:0] r_idx, r_i, r_j;

  logic       w_start, w_dims_ok, w_nonempty, w_capture, w_zero, w_last;
  logic [4:0] w_total;
  logic [W-1:0] w_elem;
  mat_t       w_shadow_nxt, w_pub;

  function automatic logic [3:0] clamp4(input logic [3:0] d);
    return (d > 4'd4) ? 4'd4 : d;
  endfunction

  // After reset, readybit has to be seen low before a start is accepted.
  // A readybit held high through reset therefore does not restart the block.
  assign w_start    = readybit & ~r_ready_q & r_armed;
  assign w_nonempty = (R1 != 4'd0) && (C2 != 4'd0);
  assign w_total    = {1'b0, r_r1} * {1'b0, r_c2};
  assign w_last     = ({1'b0, r_idx} == (w_total - 5'd1));

`ifdef MATMUL_DIMCHK_EN
  assign w_dims_ok = (C1 == R2) &&
                     (R1 != 4'd0) && (C1 != 4'd0) && (R2 != 4'd0) && (C2 != 4'd0) &&
                     (R1 <= 4'd4) && (C1 <= 4'd4) && (R2 <= 4'd4) && (C2 <= 4'd4);
`else
  // R2 is only used by the dimension check.
  logic w_unused_r2;
  assign w_unused_r2 = ^R2;
  assign w_dims_ok   = 1'b1;
`endif

  // Dot product of row r_i of A with column r_j of B, truncated to W bits.
  always_comb begin
    w_elem = '0;
    for (int k = 0; k < N; k++) begin
      if (4'(k) < r_c1)
        w_elem = w_elem + r_a[r_i * r_c1 + 4'(k)] * r_b[4'(k) * r_c2 + r_j];
    end
  end

  // Shadow with the current element merged in. The published copy zeroes the unused slots.
  always_comb begin
    w_shadow_nxt        = r_shadow;
    w_shadow_nxt[r_idx] = w_elem;
    w_pub               = '0;
    for (int k = 0; k < N*N; k++) begin
      if (5'(k) < w_total)
        w_pub[k] = w_shadow_nxt[k];
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic and start decode
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_zero       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (w_dims_ok && w_nonempty) begin
            w_capture    = 1'b1;
            w_next_state = COMPUTE;
          end else begin
            w_zero = 1'b1;
          end
        end
      end
      COMPUTE: begin
        if (w_last) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, element walk, shadow fill and atomic publish
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ready_q   <= 1'b0;
      r_armed     <= 1'b0;
      r_zero_pend <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_shadow    <= '0;
      r_res       <= '0;
      r_r1        <= '0;
      r_c1        <= '0;
      r_c2        <= '0;
      r_idx       <= '0;
      r_i         <= '0;
      r_j         <= '0;
    end else begin
      r_ready_q   <= readybit;
      if (!readybit) r_armed <= 1'b1;
      // An empty or rejected operation clears the result one edge after start.
      r_zero_pend <= w_zero;
      if (r_zero_pend) r_res <= '0;

      if (w_capture) begin
        r_a   <= matrix_1;
        r_b   <= matrix_2;
        r_r1  <= clamp4(R1);
        r_c1  <= clamp4(C1);
        r_c2  <= clamp4(C2);
        r_idx <= '0;
        r_i   <= '0;
        r_j   <= '0;
      end

      if (r_state == COMPUTE) begin
        r_shadow <= w_shadow_nxt;
        r_idx    <= r_idx + 4'd1;
        if (r_j == r_c2 - 4'd1) begin
          r_j <= '0;
          r_i <= r_i + 4'd1;
        end else begin
          r_j <= r_j + 4'd1;
        end
        if (w_last) r_res <= w_pub;
      end
    end
  end

  assign res_mat = r_res;

endmodule

// File: tb/tb_matrix_mult_4x4.sv
// Testbench for matrix_mult_4x4: directed operations with a scoreboard
// queue of expected results. Each result is checked at its publish edge.
module tb_matrix_mult_4x4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [255:0] matrix_1 = '0;
  logic [255:0] matrix_2 = '0;
  logic [3:0]   R1 = '0, C1 = '0, R2 = '0, C2 = '0;
  logic         readybit = 1'b0;
  logic [255:0] res_mat;

  int checks = 0;
  int errors = 0;
  logic [255:0] sb_q[$];

  matrix_mult_4x4 dut (
    .CLK(CLK), .RST(RST),
    .matrix_1(matrix_1), .matrix_2(matrix_2),
    .R1(R1), .C1(C1), .R2(R2), .C2(C2),
    .readybit(readybit), .res_mat(res_mat)
  );

  always #5 CLK = ~CLK;

  function automatic logic [255:0] put(input logic [255:0] v, input int k, input logic [15:0] x);
    v[255-16*k -: 16] = x;
    return v;
  endfunction

  function automatic logic [15:0] get(input logic [255:0] v, input int k);
    return v[255-16*k -: 16];
  endfunction

  // Reference: plain triple loop over clamped dimensions, 16-bit wraparound.
  function automatic logic [255:0] model(input logic [255:0] a, input logic [255:0] b,
                                         input int r1, input int c1, input int c2);
    logic [255:0] r = '0;
    logic [15:0]  s;
    if (r1 > 4) r1 = 4;
    if (c1 > 4) c1 = 4;
    if (c2 > 4) c2 = 4;
    for (int i = 0; i < r1; i++)
      for (int j = 0; j < c2; j++) begin
        s = '0;
        for (int k = 0; k < c1; k++)
          s = s + get(a, i*c1+k) * get(b, k*c2+j);
        r = put(r, i*c2+j, s);
      end
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start an op at edge E0 and scramble the inputs right after E0. Optionally
  // toggle readybit during COMPUTE. Check that the old result holds just before
  // E0+lat, then pop the scoreboard and check at E0+lat.
  task automatic run_op(input string tag, input logic [255:0] a, input logic [255:0] b,
                        input logic [3:0] r1, input logic [3:0] c1,
                        input logic [3:0] r2, input logic [3:0] c2,
                        input int lat, input logic [255:0] exp, input bit wiggle);
    logic [255:0] old;
    logic [255:0] e;
    @(negedge CLK);
    matrix_1 = a; matrix_2 = b;
    R1 = r1; C1 = c1; R2 = r2; C2 = c2;
    readybit = 1'b1;
    old = res_mat;
    sb_q.push_back(exp);
    @(posedge CLK);  // E0
    for (int c = 1; c <= lat; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        matrix_1 = {8{$urandom}};
        matrix_2 = {8{$urandom}};
        R1 = 4'($urandom); C1 = 4'($urandom); C2 = 4'($urandom);
        if (wiggle) readybit = 1'b0;
      end
      if (c == 2 && wiggle) readybit = 1'b1;
      if (c == lat && lat >= 2) check({tag, "_hold"}, res_mat, old);
      @(posedge CLK);  // E0+c
    end
    @(negedge CLK);
    e = sb_q.pop_front();
    check(tag, res_mat, e);
    readybit = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    logic [255:0] a, b, e;

    // Reset
    repeat (2) @(negedge CLK);
    check("reset", res_mat, 256'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // 2x2 [1,2;3,4]*[5,6;7,8] -> 19,22,43,50
    a = '0; b = '0; e = '0;
    a = put(a,0,1); a = put(a,1,2); a = put(a,2,3); a = put(a,3,4);
    b = put(b,0,5); b = put(b,1,6); b = put(b,2,7); b = put(b,3,8);
    e = put(e,0,19); e = put(e,1,22); e = put(e,2,43); e = put(e,3,50);
    run_op("mm2x2", a, b, 4'd2, 4'd2, 4'd2, 4'd2, 4, e, 1'b0);

    // 4x4 identity * A(k)=k+1, with a readybit toggle during COMPUTE
    a = '0; b = '0; e = '0;
    for (int i = 0; i < 4; i++) a = put(a, i*4+i, 16'd1);
    for (int k = 0; k < 16; k++) begin b = put(b, k, 16'(k+1)); e = put(e, k, 16'(k+1)); end
    run_op("ident4x4", a, b, 4'd4, 4'd4, 4'd4, 4'd4, 16, e, 1'b1);

    // 1x3 [1,2,3] * 3x1 [4,5,6] -> 32
    a = '0; b = '0; e = '0;
    a = put(a,0,1); a = put(a,1,2); a = put(a,2,3);
    b = put(b,0,4); b = put(b,1,5); b = put(b,2,6);
    e = put(e,0,32);
    run_op("dot1x3", a, b, 4'd1, 4'd3, 4'd3, 4'd1, 1, e, 1'b0);

    // 1x4 all 255 * 4x1 all 255 -> 260100 mod 65536
    a = '0; b = '0; e = '0;
    for (int k = 0; k < 4; k++) begin a = put(a,k,16'd255); b = put(b,k,16'd255); end
    e = put(e,0,16'd63492);
    run_op("wrap1x4", a, b, 4'd1, 4'd4, 4'd4, 4'd1, 1, e, 1'b0);

    // Random 2x3 * 3x4 and 3x4 * 4x2 against the model
    a = '0; b = '0;
    for (int k = 0; k < 16; k++) begin a = put(a,k,16'($urandom)); b = put(b,k,16'($urandom)); end
    run_op("rnd2x3x4", a, b, 4'd2, 4'd3, 4'd3, 4'd4, 8, model(a,b,2,3,4), 1'b0);
    run_op("rnd3x4x2", a, b, 4'd3, 4'd4, 4'd4, 4'd2, 6, model(a,b,3,4,2), 1'b0);

    // Empty result (R1=0): res_mat cleared at E0+1
    run_op("empty", a, b, 4'd0, 4'd2, 4'd2, 4'd2, 1, 256'd0, 1'b0);

`ifndef MATMUL_DIMCHK_EN
    // Oversized dimensions clamp to 4
    run_op("clamp", a, b, 4'd7, 4'd9, 4'd9, 4'd5, 16, model(a,b,7,9,5), 1'b0);
`endif

    // Reset mid-COMPUTE at E0+5, readybit held high afterwards
    a = '0; b = '0;
    for (int k = 0; k < 16; k++) begin a = put(a,k,16'(k+3)); b = put(b,k,16'(2*k+1)); end
    run_op("pre_rst", a, b, 4'd4, 4'd4, 4'd4, 4'd4, 16, model(a,b,4,4,4), 1'b0);
    @(negedge CLK);
    R1 = 4'd4; C1 = 4'd4; R2 = 4'd4; C2 = 4'd4;
    readybit = 1'b1;
    sb_q.push_back(256'd0);
    @(posedge CLK);          // E0
    repeat (5) @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    e = sb_q.pop_front();
    check("rst_mid", res_mat, e);
    @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    check("no_restart", res_mat, 256'd0);
    readybit = 1'b0;
    repeat (2) @(negedge CLK);

    // Recovery after reset
    a = '0; b = '0; e = '0;
    a = put(a,0,1); a = put(a,1,2); a = put(a,2,3); a = put(a,3,4);
    b = put(b,0,5); b = put(b,1,6); b = put(b,2,7); b = put(b,3,8);
    e = put(e,0,19); e = put(e,1,22); e = put(e,2,43); e = put(e,3,50);
    run_op("post_rst", a, b, 4'd2, 4'd2, 4'd2, 4'd2, 4, e, 1'b0);

`ifdef MATMUL_DIMCHK_EN
    // Mismatched inner dimension is rejected; a following valid op still works
    run_op("dimchk_bad", a, b, 4'd2, 4'd3, 4'd2, 4'd2, 1, 256'd0, 1'b0);
    run_op("dimchk_ok", a, b, 4'd2, 4'd2, 4'd2, 4'd2, 4, e, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
